noise_injector: RTL and testbench

//   Consumes pseudo-random bytes from the LFSR random generator and adds scaled

---
 rtl/noise_injector_if.sv | 25 ++
 rtl/noise_injector.sv | 139 +++++++++++++
 tb/tb_noise_injector.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/noise_injector_if.sv
// I/Q sample stream, generator byte/enable and status, grouped for noise_injector.
// The master side is the sample source / generator model; the slave side is the injector.
interface noise_injector_if #(
  parameter int STALE_CNT_W = 16
);
  logic                   bypass;
  logic [2:0]             noise_shift;
  logic [31:0]            sample_in;
  logic                   sample_in_strobe;
  logic [7:0]             rnd;
  logic                   rnd_enable;
  logic [31:0]            sample_out;
  logic                   sample_out_strobe;
  logic [STALE_CNT_W-1:0] stale_count;

  modport master (
    output bypass, noise_shift, sample_in, sample_in_strobe, rnd,
    input  rnd_enable, sample_out, sample_out_strobe, stale_count
  );

  modport slave (
    input  bypass, noise_shift, sample_in, sample_in_strobe, rnd,
    output rnd_enable, sample_out, sample_out_strobe, stale_count
  );
endinterface

// File: rtl/noise_injector.sv
// Adds scaled signed LFSR noise to a 16+16-bit I/Q stream with saturation.
// A fetch FSM clocks 8 fresh generator bits into each noise byte before it is used.
module noise_injector #(
  parameter int STALE_CNT_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  noise_injector_if.slave sif
);

  localparam logic [2:0] FILL_I  = 3'd0;
  localparam logic [2:0] LATCH_I = 3'd1;
  localparam logic [2:0] FILL_Q  = 3'd2;
  localparam logic [2:0] LATCH_Q = 3'd3;
  localparam logic [2:0] READY   = 3'd4;

  logic [2:0]             r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_noise_i;
  logic [7:0]             r_noise_q;
  logic [7:0]             r_last_i;
  logic [7:0]             r_last_q;
  logic                   r_pair_ready;
  logic [STALE_CNT_W-1:0] r_stale_count;

  logic                   r_s1_valid;
  logic                   r_s1_bypass;
  logic [31:0]            r_s1_sample;
  logic                   r_out_strobe;
  logic [31:0]            r_sample_out;

  logic                   w_consume;
  logic                   w_stale;
  logic [7:0]             w_noise_byte [2];
  logic [15:0]            w_sat [2];

  assign w_consume = sif.sample_in_strobe & r_pair_ready;
  assign w_stale   = sif.sample_in_strobe & ~r_pair_ready;

  // Gated by reset so the generator sees no enable while it is itself being reset.
  assign sif.rnd_enable = ~reset & ((r_state == FILL_I) | (r_state == FILL_Q));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FILL_I;
      r_bit_cnt    <= 3'd0;
      r_noise_i    <= 8'd0;
      r_noise_q    <= 8'd0;
      r_last_i     <= 8'd0;
      r_last_q     <= 8'd0;
      r_pair_ready <= 1'b0;
    end else if (w_consume) begin
      r_last_i     <= r_noise_i;
      r_last_q     <= r_noise_q;
      r_pair_ready <= 1'b0;
      r_state      <= FILL_I;
      r_bit_cnt    <= 3'd0;
    end else begin
      case (r_state)
        FILL_I: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= LATCH_I;
        end
        LATCH_I: begin
          r_noise_i <= sif.rnd;
          r_state   <= FILL_Q;
        end
        FILL_Q: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= LATCH_Q;
        end
        LATCH_Q: begin
          r_noise_q    <= sif.rnd;
          r_pair_ready <= 1'b1;
          r_state      <= READY;
        end
        READY:   r_state <= READY;
        default: r_state <= FILL_I;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stale_count <= '0;
    end else if (w_stale && !(&r_stale_count)) begin
      r_stale_count <= r_stale_count + 1'b1;
    end
  end

  // A fresh pair goes straight into the datapath on the consuming edge.
  assign w_noise_byte[1] = w_consume ? r_noise_i : r_last_i;
  assign w_noise_byte[0] = w_consume ? r_noise_q : r_last_q;

  // Lane 1 is I (upper half), lane 0 is Q (lower half).
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic signed [16:0] w_noise;
    logic signed [16:0] w_sum;
    logic signed [16:0] r_sum;

    assign w_noise = $signed({{9{w_noise_byte[gi][7]}}, w_noise_byte[gi]}) <<< sif.noise_shift;
    assign w_sum   = $signed({sif.sample_in[gi*16+15], sif.sample_in[gi*16 +: 16]}) + w_noise;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_sum <= '0;
      end else if (sif.sample_in_strobe) begin
        r_sum <= w_sum;
      end
    end

    assign w_sat[gi] = (r_sum[16] != r_sum[15]) ? {r_sum[16], {15{~r_sum[16]}}} : r_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_bypass  <= 1'b0;
      r_s1_sample  <= 32'd0;
      r_out_strobe <= 1'b0;
      r_sample_out <= 32'd0;
    end else begin
      r_s1_valid <= sif.sample_in_strobe;
      if (sif.sample_in_strobe) begin
        r_s1_bypass <= sif.bypass;
        r_s1_sample <= sif.sample_in;
      end
      r_out_strobe <= r_s1_valid;
      if (r_s1_valid) begin
        r_sample_out <= r_s1_bypass ? r_s1_sample : {w_sat[1], w_sat[0]};
      end
    end
  end

  assign sif.sample_out        = r_sample_out;
  assign sif.sample_out_strobe = r_out_strobe;
  assign sif.stale_count       = r_stale_count;

endmodule

// File: tb/tb_noise_injector.sv
// Directed bench for noise_injector: a timeline-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_noise_injector;

  logic clock = 1'b0;
  logic reset;

  noise_injector_if #(.STALE_CNT_W(16)) sif ();

  noise_injector #(.STALE_CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Model: m_phase counts cycles since the refill started; pair is ready after 18.
  int          m_phase;
  bit          m_ready;
  logic [7:0]  m_ni, m_nq, m_li, m_lq;
  int          m_stale;
  bit          m_pend_v;
  logic [31:0] m_pend;
  bit          m_out_v;
  logic [31:0] m_out;
  bit          m_started = 1'b0;

  function automatic logic [15:0] add_sat(input logic [15:0] s, input logic [7:0] b,
                                          input logic [2:0] sh);
    int v;
    v = int'($signed(s)) + int'($signed(b)) * (1 << sh);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_phase = 0; m_ready = 0;
        m_ni = 0; m_nq = 0; m_li = 0; m_lq = 0;
        m_stale = 0; m_pend_v = 0; m_pend = 0; m_out_v = 0; m_out = 0;
        m_started = 1;
      end else if (m_started) begin
        bit consumed;
        consumed = 0;
        m_out_v = m_pend_v;
        if (m_pend_v) m_out = m_pend;
        m_pend_v = 0;
        if (sif.sample_in_strobe) begin
          if (m_ready) begin
            m_li = m_ni; m_lq = m_nq; consumed = 1;
          end else if (m_stale < 65535) begin
            m_stale++;
          end
          m_pend_v = 1;
          m_pend = sif.bypass ? sif.sample_in :
                   {add_sat(sif.sample_in[31:16], m_li, sif.noise_shift),
                    add_sat(sif.sample_in[15:0],  m_lq, sif.noise_shift)};
        end
        if (consumed) begin
          m_phase = 0; m_ready = 0;
        end else if (!m_ready) begin
          if (m_phase == 8) m_ni = sif.rnd;
          if (m_phase == 17) begin m_nq = sif.rnd; m_ready = 1; end
          m_phase++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (m_started) begin
        logic exp_en;
        exp_en = !reset && !m_ready && (m_phase < 8 || (m_phase >= 9 && m_phase < 17));
        check("model rnd_enable", 32'(sif.rnd_enable), 32'(exp_en));
        check("model out_strobe", 32'(sif.sample_out_strobe), 32'(m_out_v));
        check("model sample_out", sif.sample_out, m_out);
        check("model stale_count", 32'(sif.stale_count), 32'(m_stale));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    sif.sample_in        = {i, q};
    sif.sample_in_strobe = 1'b1;
    step(1);
    sif.sample_in_strobe = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] exp);
    bit seen;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clock);
      if (sif.sample_out_strobe) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no output strobe within 6 cycles, expected %h", name, exp);
    end else begin
      check(name, sif.sample_out, exp);
    end
  endtask

  initial begin
    logic [17:0] pat18;
    logic [8:0]  pat9;
    reset = 1'b1;
    sif.bypass = 1'b0;
    sif.noise_shift = 3'd2;
    sif.sample_in = 32'd0;
    sif.sample_in_strobe = 1'b0;
    sif.rnd = 8'h05;
    step(2);
    reset = 1'b0;

    // 1: enable pattern 8 high, 1 low, 8 high, 1 low, then hold in READY
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      pat18[17-i] = sif.rnd_enable;
    end
    check("t1 enable pattern", 32'(pat18), 32'(18'b111111110111111110));
    step(1);
    @(negedge clock);
    check("t1 ready no enable", 32'(sif.rnd_enable), 32'd0);
    step(1);

    // 2: noise 5<<2 = 20 on both components, two-cycle latency
    send(16'h0064, 16'hFF9C);
    sif.rnd = 8'h7F;
    sif.noise_shift = 3'd7;
    @(negedge clock);
    check("t2 no early strobe", 32'(sif.sample_out_strobe), 32'd0);
    @(negedge clock);
    check("t2 strobe at +2", 32'(sif.sample_out_strobe), 32'd1);
    check("t2 value", sif.sample_out, {16'h0078, 16'hFFB0});
    check("t2 stale", 32'(sif.stale_count), 32'd0);
    step(20);

    // 3: positive and negative saturation
    send(16'h7FF8, 16'h0000);
    sif.rnd = 8'h80;
    sif.noise_shift = 3'd0;
    expect_out("t3 pos sat", {16'h7FFF, 16'h3F80});
    step(20);
    send(16'h8000, 16'h0005);
    sif.rnd = 8'h05;
    sif.noise_shift = 3'd2;
    expect_out("t3 neg sat", {16'h8000, 16'hFF85});
    step(20);

    // 4: five back-to-back strobes, then a strobe in the LATCH_Q cycle
    for (int k = 0; k < 5; k++) begin
      sif.sample_in = {16'(k * 10), 16'(k)};
      sif.sample_in_strobe = 1'b1;
      step(1);
    end
    sif.sample_in_strobe = 1'b0;
    sif.rnd = 8'h0A;
    check("t4 stale after burst", 32'(sif.stale_count), 32'd4);
    step(13);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    expect_out("t4 latchq uses old pair", {16'h0014, 16'h0014});
    expect_out("t4 next uses new pair", {16'h0028, 16'h0028});
    check("t4 stale total", 32'(sif.stale_count), 32'd5);
    step(20);

    // 5: bypass passes through, still consumes the pair
    sif.bypass = 1'b1;
    send(16'h04D2, 16'hFFFB);
    sif.bypass = 1'b0;
    @(negedge clock);
    check("t5 refill restarted", 32'(sif.rnd_enable), 32'd1);
    check("t5 no early strobe", 32'(sif.sample_out_strobe), 32'd0);
    @(negedge clock);
    check("t5 strobe at +2", 32'(sif.sample_out_strobe), 32'd1);
    check("t5 bypass value", sif.sample_out, {16'h04D2, 16'hFFFB});
    step(20);

    // 6: reset one cycle after a strobe kills the in-flight sample
    send(16'h0007, 16'h0007);
    reset = 1'b1;
    step(1);
    @(negedge clock);
    check("t6 out_strobe", 32'(sif.sample_out_strobe), 32'd0);
    check("t6 sample_out", sif.sample_out, 32'd0);
    check("t6 stale", 32'(sif.stale_count), 32'd0);
    check("t6 enable in reset", 32'(sif.rnd_enable), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      pat9[8-i] = sif.rnd_enable;
    end
    check("t6 enable group", 32'(pat9), 32'(9'b111111110));
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
